// File: rtl/counter_mod_m_tick_updn.sv
// rtl/counter_mod_m_tick_updn.sv - prescaled modulo-M up/down counter with tick and terminal-count pulses
module counter_mod_m_tick_updn #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 1,
    parameter int M       = 10,
    localparam int N      = ($clog2(M + 1) < 1) ? 1 : $clog2(M + 1)
) (
    input  logic         CLOCK_50,
    input  logic         aclr,
    input  logic         enable,
    input  logic         up,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] Q,
    output logic         tick,
    output logic         tc
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] P_ZERO = '0;
    localparam logic [N-1:0]  Q_LAST = N'(M - 1);
    localparam logic [N-1:0]  Q_ZERO = '0;

    logic [PW-1:0] p;
    logic          p_wrap;
    logic [N-1:0]  q_step;
    logic          q_wrap;
    logic [N-1:0]  load_sat;

    // The counter only advances on the enabled edge where the prescaler rolls over.
    assign p_wrap = enable && (p == P_LAST);

    always_comb begin
        q_step = Q;
        q_wrap = 1'b0;
        if (up) begin
            if (Q >= Q_LAST) begin
                q_step = Q_ZERO;
                q_wrap = 1'b1;
            end else begin
                q_step = Q + 1'b1;
            end
        end else begin
            if (Q == Q_ZERO) begin
                q_step = Q_LAST;
                q_wrap = 1'b1;
            end else begin
                q_step = Q - 1'b1;
            end
        end
    end

    // Out-of-range load values clamp to the top of the count range.
    assign load_sat = (load_val > Q_LAST) ? Q_LAST : load_val;

    always_ff @(posedge CLOCK_50) begin
        if (aclr) begin
            p    <= P_ZERO;
            Q    <= Q_ZERO;
            tick <= 1'b0;
            tc   <= 1'b0;
        end else if (load) begin
            p    <= P_ZERO;
            Q    <= load_sat;
            tick <= 1'b0;
            tc   <= 1'b0;
        end else if (p_wrap) begin
            p    <= P_ZERO;
            Q    <= q_step;
            tick <= 1'b1;
            tc   <= q_wrap;
        end else begin
            if (enable) begin
                p <= p + 1'b1;
            end
            tick <= 1'b0;
            tc   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_counter_mod_m_tick_updn.sv
// tb/tb_counter_mod_m_tick_updn.sv - directed vector bench for counter_mod_m_tick_updn
module tb_counter_mod_m_tick_updn;

    logic       clk;
    logic       aclr, enable, up, load;
    logic [3:0] load_val;
    logic [3:0] q;
    logic       tick, tc;

    logic       s_aclr, s_enable, s_up, s_load;
    logic [1:0] s_lv2;
    logic [4:0] s_lv16;
    logic [1:0] q2;
    logic [4:0] q16;
    logic       tick2, tc2, tick16, tc16;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       aclr;
        logic       enable;
        logic       up;
        logic       load;
        logic [3:0] lv;
        logic [3:0] q;
        logic       tick;
        logic       tc;
    } vec_t;

    vec_t vecs[$];

    counter_mod_m_tick_updn #(.CLK_HZ(8), .TICK_HZ(2), .M(10)) u_main (
        .CLOCK_50(clk), .aclr(aclr), .enable(enable), .up(up), .load(load),
        .load_val(load_val), .Q(q), .tick(tick), .tc(tc)
    );

    counter_mod_m_tick_updn #(.CLK_HZ(1), .TICK_HZ(1), .M(2)) u_m2 (
        .CLOCK_50(clk), .aclr(s_aclr), .enable(s_enable), .up(s_up), .load(s_load),
        .load_val(s_lv2), .Q(q2), .tick(tick2), .tc(tc2)
    );

    counter_mod_m_tick_updn #(.CLK_HZ(1), .TICK_HZ(1), .M(16)) u_m16 (
        .CLOCK_50(clk), .aclr(s_aclr), .enable(s_enable), .up(s_up), .load(s_load),
        .load_val(s_lv16), .Q(q16), .tick(tick16), .tc(tc16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s [%0d] actual %0d required %0d", nm, idx, act, exp);
        end
    endtask

    task automatic add(input logic a, input logic e, input logic u, input logic l,
                       input int lv, input int eq, input logic et, input logic ec);
        vec_t v;
        v.aclr = a; v.enable = e; v.up = u; v.load = l;
        v.lv = 4'(lv); v.q = 4'(eq); v.tick = et; v.tc = ec;
        vecs.push_back(v);
    endtask

    task automatic add_n(input int n, input logic e, input logic u, input int eq);
        for (int i = 0; i < n; i++) add(0, e, u, 0, 0, eq, 0, 0);
    endtask

    task automatic sweep_step(input int idx, input int e2, input int et2, input int ec2,
                              input int e16, input int et16, input int ec16);
        @(posedge clk);
        #1;
        chk("m2_q", idx, int'(q2), e2);
        chk("m2_tick", idx, int'(tick2), et2);
        chk("m2_tc", idx, int'(tc2), ec2);
        chk("m2_range", idx, int'(q2 < 2'd2), 1);
        chk("m16_q", idx, int'(q16), e16);
        chk("m16_tick", idx, int'(tick16), et16);
        chk("m16_tc", idx, int'(tc16), ec16);
        chk("m16_range", idx, int'(q16 < 5'd16), 1);
    endtask

    initial begin
        aclr = 1; enable = 0; up = 0; load = 0; load_val = 0;
        s_aclr = 1; s_enable = 0; s_up = 0; s_load = 0; s_lv2 = 0; s_lv16 = 0;

        // reset, then 44 enabled up cycles with DIV=4
        add(1, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 1; c <= 44; c++)
            add(0, 1, 1, 0, 0, (c / 4) % 10, (c % 4) == 0, ((c % 4) == 0) && (((c / 4) % 10) == 0));
        // counting down from 0 wraps to 9 with tc
        add(1, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 1; c <= 12; c++)
            add(0, 1, 0, 0, 0, (10 - c / 4) % 10, (c % 4) == 0, c == 4);
        // load mid-interval, saturation, held load, then 4 cycles to step
        add_n(2, 1, 1, 7);
        add(0, 1, 1, 1, 15, 9, 0, 0);
        add(0, 1, 1, 1, 7, 7, 0, 0);
        add_n(3, 1, 1, 7);
        add(0, 1, 1, 0, 0, 8, 1, 0);
        // direction change mid-interval does not disturb the prescaler
        add_n(2, 1, 1, 8);
        add(0, 1, 0, 0, 0, 8, 0, 0);
        add(0, 1, 0, 0, 0, 7, 1, 0);
        // freeze at P=2 for 10 cycles, resume needs 2 more cycles
        add_n(2, 1, 1, 7);
        add_n(10, 0, 1, 7);
        add(0, 1, 1, 0, 0, 7, 0, 0);
        add(0, 1, 1, 0, 0, 8, 1, 0);
        add(0, 0, 1, 0, 0, 8, 0, 0);
        // load works with enable low; up wrap from loaded 9
        add(0, 0, 1, 1, 12, 9, 0, 0);
        add_n(3, 1, 1, 9);
        add(0, 1, 1, 0, 0, 0, 1, 1);
        // aclr coincident with load and a would-be wrap edge
        add(0, 1, 1, 1, 4, 4, 0, 0);
        add_n(3, 1, 1, 4);
        add(1, 1, 1, 1, 5, 0, 0, 0);
        add_n(3, 1, 1, 0);
        add(0, 1, 1, 0, 0, 1, 1, 0);
        // aclr mid-interval discards prescaler progress
        add_n(2, 1, 1, 1);
        add(1, 1, 1, 0, 0, 0, 0, 0);
        add_n(3, 1, 1, 0);
        add(0, 1, 1, 0, 0, 1, 1, 0);

        foreach (vecs[i]) begin
            aclr = vecs[i].aclr; enable = vecs[i].enable; up = vecs[i].up;
            load = vecs[i].load; load_val = vecs[i].lv;
            @(posedge clk);
            #1;
            chk("q", i, int'(q), int'(vecs[i].q));
            chk("tick", i, int'(tick), int'(vecs[i].tick));
            chk("tc", i, int'(tc), int'(vecs[i].tc));
            chk("q_range", i, int'(q < 4'd10), 1);
        end

        // DIV=1 sweep with M=2 and M=16
        sweep_step(0, 0, 0, 0, 0, 0, 0);
        s_aclr = 0; s_enable = 1; s_up = 1;
        for (int c = 1; c <= 18; c++)
            sweep_step(c, c % 2, 1, (c % 2) == 0, c % 16, 1, (c % 16) == 0);
        s_up = 0;
        for (int d = 1; d <= 3; d++)
            sweep_step(100 + d, d % 2, 1, d % 2, (18 - d) % 16, 1, d == 3);
        s_enable = 0;
        sweep_step(200, 1, 0, 0, 15, 0, 0);
        s_load = 1; s_lv2 = 2'd3; s_lv16 = 5'd31;
        sweep_step(201, 1, 0, 0, 15, 0, 0);
        s_lv2 = 2'd2; s_lv16 = 5'd16;
        sweep_step(202, 1, 0, 0, 15, 0, 0);
        s_lv2 = 2'd0; s_lv16 = 5'd3;
        sweep_step(203, 0, 0, 0, 3, 0, 0);
        s_load = 0; s_enable = 1; s_up = 1;
        sweep_step(204, 1, 1, 0, 4, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_mod_m_tick_updn.md
COUNTER_MOD_M_TICK_UPDN -- requirements
Module: counter_mod_M_tick_updn

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 1, counting rate in Hz; DIV = CLK_HZ/TICK_HZ (integer division), DIV >= 1 required.
REQ-003 SHALL have parameter M, default 10, counter modulus, M >= 2; N = number of bits needed to hold M (10 -> 4), minimum 1.
REQ-004 SHALL have port CLOCK_50  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port aclr  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port enable  input  1  count enable; low freezes prescaler and counter.
REQ-007 SHALL have port up  input  1  direction; 1 = count up, 0 = count down.
REQ-008 SHALL have port load  input  1  synchronous load strobe.
REQ-009 SHALL have port load_val  input  N  value loaded into Q.
REQ-010 SHALL have port Q  output  N  counter value, range 0..M-1.
REQ-011 SHALL have port tick  output  1  one-cycle pulse when the prescaler wraps.
REQ-012 SHALL have port tc  output  1  one-cycle terminal-count pulse when Q wraps.

Function
REQ-013 Prescaler SHALL be a registered count P, width sufficient for DIV-1, stepping 0..DIV-1 then 0 on each enabled cycle.
REQ-014 tick SHALL be registered, asserted in the cycle after the edge at which P advanced from DIV-1 to 0, for exactly one cycle; DIV = 1 gives tick high on every cycle following an enabled cycle.
REQ-015 Q SHALL step once per prescaler wrap, updating on the same edge at which P goes DIV-1 -> 0 (tick and new Q visible together).
REQ-016 Up step: Q+1, with M-1 -> 0; down step: Q-1, with 0 -> M-1.
REQ-017 tc SHALL be registered, high for one cycle together with the Q value produced by a wrap (M-1 -> 0 up, 0 -> M-1 down), otherwise low.
REQ-018 up SHALL be sampled at the stepping edge; a change of up between steps takes effect at the next step without disturbing P.
REQ-019 enable low: P, Q held; tick and tc forced low next cycle; resuming continues from held P (no lost or extra step).
REQ-020 load high (priority over stepping, independent of enable): Q <= load_val, P <= 0, tick <= 0, tc <= 0.
REQ-021 load_val >= M SHALL load M-1 (saturate).
REQ-022 load held high SHALL keep P at 0 and reload Q every cycle; counting resumes DIV enabled cycles after load falls.
REQ-023 Priority, highest first: aclr, load, enable-gated stepping.
REQ-024 Q SHALL never hold a value >= M under any input sequence.

Reset
REQ-025 aclr high at a rising edge SHALL set P = 0, Q = 0, tick = 0, tc = 0, overriding load and enable.
REQ-026 aclr asserted mid-interval SHALL discard partial prescaler progress; first step after release occurs DIV enabled cycles later.
REQ-027 No output SHALL change asynchronously to CLOCK_50.

Verification (CLK_HZ=8, TICK_HZ=2 -> DIV=4, M=10 unless stated)
REQ-028 Reset then enable=1, up=1 for 44 cycles -> Q steps every 4 cycles 0,1,...,9,0; tick pulses every 4th cycle; tc high only with Q=0 after 9.
REQ-029 up=0 from Q=0 -> next step gives Q=9 with tc=1, then 8,7,... with tc=0.
REQ-030 load=1, load_val=7 mid-interval -> Q=7, P=0 next cycle; load_val=15 -> Q=9; next step exactly 4 enabled cycles after load falls.
REQ-031 enable low 10 cycles at P=2 -> Q, P frozen, tick/tc low; after re-enable step occurs after 2 more cycles.
REQ-032 aclr=1 coincident with load=1 and a wrap edge -> Q=0, tick=0, tc=0.
REQ-033 Parameter sweep DIV=1, M=2 and M=16 -> N=2/5, Q toggles/wraps correctly each step, never >= M.
